// File: rtl/al_clk_pkg.sv
// Shared types and constants for the alarm-clock keypad time-entry path.
package al_clk_pkg;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam int         MAX_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } key_state_e;

    typedef struct packed {
        logic [3:0] ms_hour;
        logic [3:0] ls_hour;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/al_bcd_time_check.sv
// Combinational HH:MM BCD validity check; any non-decimal nibble makes the time invalid.
module al_bcd_time_check
    import al_clk_pkg::*;
(
    input  bcd_time_t i_time,
    output logic      o_valid
);

    logic w_hour_ok;
    logic w_min_ok;

    always_comb begin
        w_hour_ok = (i_time.ms_hour <= 4'd2) && (i_time.ls_hour <= 4'd9)
                  && !((i_time.ms_hour == 4'd2) && (i_time.ls_hour > 4'd3));
        w_min_ok  = (i_time.ms_min <= 4'd5) && (i_time.ls_min <= 4'd9);
        o_valid   = w_hour_ok && w_min_ok;
    end

endmodule

// File: rtl/al_clk_key_entry.sv
// Keypad HH:MM entry FSM feeding the time counter's time_in/load_new_time inputs.
// Optional idle-timeout abandonment is built when AL_KEY_TIMEOUT_EN is defined.
module al_clk_key_entry
    import al_clk_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 2560,
    parameter int TMR_W         = 12
) (
    input  logic        clk256,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] time_out,
    output logic        load_new_time,
    output logic [15:0] entry_buf,
    output logic [2:0]  digit_cnt,
    output logic        entry_active,
    output logic        entry_error
);

    key_state_e  r_state, w_state_next;
    logic [15:0] r_buf, w_buf_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic [15:0] r_time, w_time_next;
    logic        r_load, w_load_next;
    logic        r_err, w_err_next;
    logic        w_valid;
    logic        w_expired;

    al_bcd_time_check u_check (
        .i_time  (bcd_time_t'(r_buf)),
        .o_valid (w_valid)
    );

`ifdef AL_KEY_TIMEOUT_EN
    logic [TMR_W-1:0] r_tmr;

    // Counts idle cycles in ENTRY only; any key (even an ignored code) restarts it.
    always_ff @(posedge clk256) begin
        if (!reset_n || r_state != ENTRY || key_valid)
            r_tmr <= '0;
        else
            r_tmr <= r_tmr + 1'b1;
    end

    assign w_expired = (r_tmr == TMR_W'(TIMEOUT_TICKS - 1));
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf;
        w_cnt_next   = r_cnt;
        w_time_next  = r_time;
        w_load_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    w_buf_next   = {12'h000, key_code};
                    w_cnt_next   = 3'd1;
                    w_state_next = ENTRY;
                end
            end
            ENTRY: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        w_buf_next = {r_buf[11:0], key_code};
                        if (r_cnt != 3'(MAX_DIGITS))
                            w_cnt_next = r_cnt + 3'd1;
                    end else if (key_code == KEY_ENTER) begin
                        if (r_cnt == 3'(MAX_DIGITS) && w_valid) begin
                            w_state_next = LOAD;
                        end else begin
                            w_err_next   = 1'b1;
                            w_buf_next   = '0;
                            w_cnt_next   = '0;
                            w_state_next = IDLE;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_buf_next   = '0;
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end
                end else if (w_expired) begin
                    w_buf_next   = '0;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end
            end
            LOAD: begin
                // Keys arriving here are deliberately dropped.
                w_time_next  = r_buf;
                w_load_next  = 1'b1;
                w_buf_next   = '0;
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_buf_next   = '0;
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk256) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_time  <= '0;
            r_load  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_buf   <= w_buf_next;
            r_cnt   <= w_cnt_next;
            r_time  <= w_time_next;
            r_load  <= w_load_next;
            r_err   <= w_err_next;
        end
    end

    assign time_out      = r_time;
    assign load_new_time = r_load;
    assign entry_buf     = r_buf;
    assign digit_cnt     = r_cnt;
    assign entry_active  = (r_state == ENTRY);
    assign entry_error   = r_err;

endmodule

// File: tb/tb_al_clk_key_entry.sv
// Table-driven bench for al_clk_key_entry; timeout vectors use TIMEOUT_TICKS=8 when AL_KEY_TIMEOUT_EN is set.
module tb_al_clk_key_entry;

    localparam int TB_TICKS = 8;
    localparam int TB_TMR_W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] time_out;
    logic        load_new_time;
    logic [15:0] entry_buf;
    logic [2:0]  digit_cnt;
    logic        entry_active;
    logic        entry_error;

    int total = 0;
    int bad   = 0;

    al_clk_key_entry #(
        .TIMEOUT_TICKS (TB_TICKS),
        .TMR_W         (TB_TMR_W)
    ) dut (
        .clk256        (clk),
        .reset_n       (reset_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .time_out      (time_out),
        .load_new_time (load_new_time),
        .entry_buf     (entry_buf),
        .digit_cnt     (digit_cnt),
        .entry_active  (entry_active),
        .entry_error   (entry_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        kv;
        logic [3:0]  kc;
        logic        ld;
        logic        er;
        logic        act;
        logic [2:0]  cnt;
        logic [15:0] eb;
        logic [15:0] to;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    // Add one cycle: inputs for the cycle, then outputs required just after the edge.
    task automatic mk(input string n, input logic rst, input logic kv, input logic [3:0] kc,
                      input logic ld, input logic er, input logic act, input int cnt,
                      input logic [15:0] eb, input logic [15:0] to);
        vec_t v;
        v.name = n; v.rst = rst; v.kv = kv; v.kc = kc;
        v.ld = ld; v.er = er; v.act = act; v.cnt = 3'(cnt); v.eb = eb; v.to = to;
        tbl.push_back(v);
    endtask

    task automatic check(input vec_t e);
        total++;
        if (load_new_time !== e.ld || entry_error !== e.er || entry_active !== e.act ||
            digit_cnt !== e.cnt || entry_buf !== e.eb || time_out !== e.to) begin
            bad++;
            $display("FAIL %s: got ld=%b er=%b act=%b cnt=%0d buf=%h tout=%h, want ld=%b er=%b act=%b cnt=%0d buf=%h tout=%h",
                     e.name, load_new_time, entry_error, entry_active, digit_cnt, entry_buf, time_out,
                     e.ld, e.er, e.act, e.cnt, e.eb, e.to);
        end else begin
            $display("ok   %s: ld=%b er=%b act=%b cnt=%0d buf=%h tout=%h",
                     e.name, load_new_time, entry_error, entry_active, digit_cnt, entry_buf, time_out);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic check_val(input string n, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end else begin
            $display("ok   %s: %0d", n, got);
        end
    endtask

    initial begin
        vec_t e;
        int   lat;

        // reset and ignored keys in IDLE
        mk("reset",       1, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        mk("idle_enter",  0, 1, 4'hA, 0, 0, 0, 0, 16'h0000, 16'h0000);
        mk("idle_clear",  0, 1, 4'hB, 0, 0, 0, 0, 16'h0000, 16'h0000);
        mk("idle_ign",    0, 1, 4'hC, 0, 0, 0, 0, 16'h0000, 16'h0000);
        // 12:34 accepted
        mk("t1_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h0000);
        mk("t1_k2",       0, 1, 4'h2, 0, 0, 1, 2, 16'h0012, 16'h0000);
        mk("t1_k3",       0, 1, 4'h3, 0, 0, 1, 3, 16'h0123, 16'h0000);
        mk("t1_k4",       0, 1, 4'h4, 0, 0, 1, 4, 16'h1234, 16'h0000);
        mk("t1_enter",    0, 1, 4'hA, 0, 0, 0, 4, 16'h1234, 16'h0000);
        mk("t1_load",     0, 0, 4'h0, 1, 0, 0, 0, 16'h0000, 16'h1234);
        mk("t1_after",    0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h1234);
        // 24:00 rejected
        mk("t2_k2",       0, 1, 4'h2, 0, 0, 1, 1, 16'h0002, 16'h1234);
        mk("t2_k4",       0, 1, 4'h4, 0, 0, 1, 2, 16'h0024, 16'h1234);
        mk("t2_k0a",      0, 1, 4'h0, 0, 0, 1, 3, 16'h0240, 16'h1234);
        mk("t2_k0b",      0, 1, 4'h0, 0, 0, 1, 4, 16'h2400, 16'h1234);
        mk("t2_enter",    0, 1, 4'hA, 0, 1, 0, 0, 16'h0000, 16'h1234);
        mk("t2_after",    0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h1234);
        // five digits: oldest dropped, ignored code in ENTRY holds
        mk("t3_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h1234);
        mk("t3_k2",       0, 1, 4'h2, 0, 0, 1, 2, 16'h0012, 16'h1234);
        mk("t3_k3",       0, 1, 4'h3, 0, 0, 1, 3, 16'h0123, 16'h1234);
        mk("t3_k4",       0, 1, 4'h4, 0, 0, 1, 4, 16'h1234, 16'h1234);
        mk("t3_k5",       0, 1, 4'h5, 0, 0, 1, 4, 16'h2345, 16'h1234);
        mk("t3_ign",      0, 1, 4'hE, 0, 0, 1, 4, 16'h2345, 16'h1234);
        mk("t3_enter",    0, 1, 4'hA, 0, 0, 0, 4, 16'h2345, 16'h1234);
        mk("t3_load",     0, 0, 4'h0, 1, 0, 0, 0, 16'h0000, 16'h2345);
        mk("t3_after",    0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h2345);
        // CLEAR, then short entry rejected
        mk("t4_k0",       0, 1, 4'h0, 0, 0, 1, 1, 16'h0000, 16'h2345);
        mk("t4_k9",       0, 1, 4'h9, 0, 0, 1, 2, 16'h0009, 16'h2345);
        mk("t4_clear",    0, 1, 4'hB, 0, 0, 0, 0, 16'h0000, 16'h2345);
        mk("t4_enter_idle",0,1, 4'hA, 0, 0, 0, 0, 16'h0000, 16'h2345);
        mk("t4b_k0",      0, 1, 4'h0, 0, 0, 1, 1, 16'h0000, 16'h2345);
        mk("t4b_k9",      0, 1, 4'h9, 0, 0, 1, 2, 16'h0009, 16'h2345);
        mk("t4b_enter",   0, 1, 4'hA, 0, 1, 0, 0, 16'h0000, 16'h2345);
        mk("t4b_after",   0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h2345);
        // key during LOAD is dropped
        mk("dl_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h2345);
        mk("dl_k3",       0, 1, 4'h3, 0, 0, 1, 2, 16'h0013, 16'h2345);
        mk("dl_k5",       0, 1, 4'h5, 0, 0, 1, 3, 16'h0135, 16'h2345);
        mk("dl_k9",       0, 1, 4'h9, 0, 0, 1, 4, 16'h1359, 16'h2345);
        mk("dl_enter",    0, 1, 4'hA, 0, 0, 0, 4, 16'h1359, 16'h2345);
        mk("dl_key_load", 0, 1, 4'h7, 1, 0, 0, 0, 16'h0000, 16'h1359);
        mk("dl_after",    0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h1359);
        // 23:60 rejected (minutes tens > 5)
        mk("bm_k2",       0, 1, 4'h2, 0, 0, 1, 1, 16'h0002, 16'h1359);
        mk("bm_k3",       0, 1, 4'h3, 0, 0, 1, 2, 16'h0023, 16'h1359);
        mk("bm_k6",       0, 1, 4'h6, 0, 0, 1, 3, 16'h0236, 16'h1359);
        mk("bm_k0",       0, 1, 4'h0, 0, 0, 1, 4, 16'h2360, 16'h1359);
        mk("bm_enter",    0, 1, 4'hA, 0, 1, 0, 0, 16'h0000, 16'h1359);
        // 00:00 accepted
        mk("z_k0a",       0, 1, 4'h0, 0, 0, 1, 1, 16'h0000, 16'h1359);
        mk("z_k0b",       0, 1, 4'h0, 0, 0, 1, 2, 16'h0000, 16'h1359);
        mk("z_k0c",       0, 1, 4'h0, 0, 0, 1, 3, 16'h0000, 16'h1359);
        mk("z_k0d",       0, 1, 4'h0, 0, 0, 1, 4, 16'h0000, 16'h1359);
        mk("z_enter",     0, 1, 4'hA, 0, 0, 0, 4, 16'h0000, 16'h1359);
        mk("z_load",      0, 0, 4'h0, 1, 0, 0, 0, 16'h0000, 16'h0000);
        // reset mid-entry, then 23:59
        mk("t6_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h0000);
        mk("t6_k5",       0, 1, 4'h5, 0, 0, 1, 2, 16'h0015, 16'h0000);
        mk("t6_reset",    1, 1, 4'hA, 0, 0, 0, 0, 16'h0000, 16'h0000);
        mk("t6_k2",       0, 1, 4'h2, 0, 0, 1, 1, 16'h0002, 16'h0000);
        mk("t6_k3",       0, 1, 4'h3, 0, 0, 1, 2, 16'h0023, 16'h0000);
        mk("t6_k5b",      0, 1, 4'h5, 0, 0, 1, 3, 16'h0235, 16'h0000);
        mk("t6_k9",       0, 1, 4'h9, 0, 0, 1, 4, 16'h2359, 16'h0000);
        mk("t6_enter",    0, 1, 4'hA, 0, 0, 0, 4, 16'h2359, 16'h0000);
        mk("t6_load",     0, 0, 4'h0, 1, 0, 0, 0, 16'h0000, 16'h2359);
        mk("t6_after",    0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h2359);
`ifdef AL_KEY_TIMEOUT_EN
        // key then TB_TICKS idle cycles abandons; a key in the expiry cycle wins
        mk("to_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h2359);
        for (int i = 0; i < TB_TICKS - 1; i++)
            mk("to_wait",   0, 0, 4'h0, 0, 0, 1, 1, 16'h0001, 16'h2359);
        mk("to_expire",   0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h2359);
        mk("tk_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h2359);
        for (int i = 0; i < TB_TICKS - 1; i++)
            mk("tk_wait",   0, 0, 4'h0, 0, 0, 1, 1, 16'h0001, 16'h2359);
        mk("tk_key_exp",  0, 1, 4'h2, 0, 0, 1, 2, 16'h0012, 16'h2359);
        for (int i = 0; i < TB_TICKS - 1; i++)
            mk("tk_wait2",  0, 0, 4'h0, 0, 0, 1, 2, 16'h0012, 16'h2359);
        mk("tk_expire",   0, 0, 4'h0, 0, 0, 0, 0, 16'h0000, 16'h2359);
`else
        // without the timeout an entry persists indefinitely
        mk("nt_k1",       0, 1, 4'h1, 0, 0, 1, 1, 16'h0001, 16'h2359);
        for (int i = 0; i < 3 * TB_TICKS; i++)
            mk("nt_wait",   0, 0, 4'h0, 0, 0, 1, 1, 16'h0001, 16'h2359);
        mk("nt_clear",    0, 1, 4'hB, 0, 0, 0, 0, 16'h0000, 16'h2359);
`endif

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            reset_n   = ~tbl[i].rst;
            key_valid = tbl[i].kv;
            key_code  = tbl[i].kc;
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check(e);
        end
        reset_n   = 1'b1;
        key_valid = 1'b0;

        // Hand sequence: measure load latency and pulse width for 02:15
        press(4'h0); press(4'h2); press(4'h1); press(4'h5);
        press(4'hA);
        check_val("lat_state_load_no_strobe", int'(load_new_time), 0);
        lat = 0;
        while (!load_new_time && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("load_latency_edges", lat, 1);
        check_val("load_time_out", int'(time_out), 16'h0215);
        @(posedge clk); #1;
        check_val("load_pulse_width", int'(load_new_time), 0);
        check_val("no_error_on_accept", int'(entry_error), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
